// File: rtl/soafa_pkg.sv
// Shared sizing constants and FSM state type for the partial-sum accumulator.
package soafa_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned NLANES = DATA_W / LANE_W;
    localparam int unsigned NBITS  = 8;
    localparam int unsigned ACC_W  = 12;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/soafa_lane_popcount.sv
// Combinational population count of one DOut lane.
module soafa_lane_popcount #(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = $clog2(LANE_W + 1)
) (
    input  logic [LANE_W-1:0] lane,
    output logic [CNT_W-1:0]  count
);

    // Sum the set bits of the lane.
    always_comb begin
        count = '0;
        for (int i = 0; i < int'(LANE_W); i++) begin
            count = count + CNT_W'(lane[i]);
        end
    end

endmodule

// File: rtl/soafa_psum_acc.sv
// Bit-serial partial-sum accumulator: folds NBITS Macro DOut planes (MSB first)
// into per-lane shift-and-add accumulators, then holds the result for the consumer.
module soafa_psum_acc #(
    parameter int unsigned DATA_W = soafa_pkg::DATA_W,
    parameter int unsigned LANE_W = soafa_pkg::LANE_W,
    parameter int unsigned NBITS  = soafa_pkg::NBITS,
    parameter int unsigned ACC_W  = soafa_pkg::ACC_W
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                Start,
    input  logic                                Signed_Mode,
    input  logic                                In_Valid,
    input  logic [DATA_W-1:0]                   In_Data,
    output logic                                In_Ready,
    output logic                                Out_Valid,
    input  logic                                Out_Ready,
    output logic [(DATA_W/LANE_W)*ACC_W-1:0]    Out_Sum,
    output logic                                Busy
);

    import soafa_pkg::*;

    localparam int unsigned NL    = DATA_W / LANE_W;
    localparam int unsigned PC_W  = $clog2(LANE_W + 1);
    localparam int unsigned CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic [NL-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [PC_W-1:0]          pc [NL];

    for (genvar k = 0; k < int'(NL); k++) begin : g_lane
        soafa_lane_popcount #(
            .LANE_W (LANE_W),
            .CNT_W  (PC_W)
        ) u_popcount (
            .lane  (In_Data[k*LANE_W +: LANE_W]),
            .count (pc[k])
        );
    end

    // Next-state, plane counter and accumulator update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                // Start wins over any concurrent In_Valid.
                if (Start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    mode_d  = Signed_Mode;
                    acc_d   = '0;
                end
            end
            StAccum: begin
                if (In_Valid) begin
                    for (int k = 0; k < int'(NL); k++) begin
                        // MSB plane carries negative weight in signed mode.
                        if (mode_q && (cnt_q == '0)) begin
                            acc_d[k] = ACC_W'(0) - ACC_W'(pc[k]);
                        end else begin
                            acc_d[k] = (acc_q[k] << 1) + ACC_W'(pc[k]);
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NBITS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (Out_Ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
        end
    end

    assign In_Ready  = (state_q == StAccum);
    assign Out_Valid = (state_q == StDone);
    assign Busy      = (state_q != StIdle);
    assign Out_Sum   = acc_q;

endmodule

// File: tb/tb_soafa_psum_acc.sv
// Directed bench with a per-cycle scoreboard built from weighted popcount sums.
module tb_soafa_psum_acc;

    localparam int DW = 64;
    localparam int LW = 8;
    localparam int NL = 8;
    localparam int NB = 8;
    localparam int AW = 12;

    logic           Clk = 1'b0;
    logic           Rst = 1'b0;
    logic           Start = 1'b0;
    logic           Signed_Mode = 1'b0;
    logic           In_Valid = 1'b0;
    logic [DW-1:0]  In_Data = '0;
    logic           In_Ready;
    logic           Out_Valid;
    logic           Out_Ready = 1'b0;
    logic [NL*AW-1:0] Out_Sum;
    logic           Busy;

    int checks = 0;
    int errors = 0;

    soafa_psum_acc dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Start       (Start),
        .Signed_Mode (Signed_Mode),
        .In_Valid    (In_Valid),
        .In_Data     (In_Data),
        .In_Ready    (In_Ready),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Out_Sum     (Out_Sum),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [NL*AW-1:0] act,
                         input logic [NL*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 accumulating, 2 result held.
    int m_phase;
    int m_n;
    bit m_mode;
    int m_sum [NL];

    function automatic int plane_weight(input int n, input bit sgn);
        int w;
        w = 1 << (NB - 1 - n);
        if (sgn && n == 0) w = -w;
        return w;
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_phase <= 0;
            m_n     <= 0;
            m_mode  <= 1'b0;
            for (int k = 0; k < NL; k++) m_sum[k] <= 0;
        end else begin
            case (m_phase)
                0: if (Start) begin
                    m_phase <= 1;
                    m_n     <= 0;
                    m_mode  <= Signed_Mode;
                    for (int k = 0; k < NL; k++) m_sum[k] <= 0;
                end
                1: if (In_Valid) begin
                    for (int k = 0; k < NL; k++)
                        m_sum[k] <= m_sum[k] + plane_weight(m_n, m_mode) *
                                    $countones(In_Data[k*LW +: LW]);
                    m_n <= m_n + 1;
                    if (m_n == NB - 1) m_phase <= 2;
                end
                default: if (Out_Ready) m_phase <= 0;
            endcase
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge Clk) begin
        if (Rst) begin
            check("in_ready", {95'd0, In_Ready}, {95'd0, m_phase == 1});
            check("out_valid", {95'd0, Out_Valid}, {95'd0, m_phase == 2});
            check("busy", {95'd0, Busy}, {95'd0, m_phase != 0});
            if (m_phase == 2) begin
                for (int k = 0; k < NL; k++)
                    check("model_lane", {84'd0, Out_Sum[k*AW +: AW]}, {84'd0, AW'(m_sum[k])});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input bit sgn, input bit with_valid);
        Start       = 1'b1;
        Signed_Mode = sgn;
        In_Valid    = with_valid;
        In_Data     = '1;
        tick();
        Start       = 1'b0;
        Signed_Mode = 1'b0;
        In_Valid    = 1'b0;
    endtask

    task automatic send_plane(input logic [DW-1:0] d, input int gap);
        In_Valid = 1'b1;
        In_Data  = d;
        tick();
        In_Valid = 1'b0;
        In_Data  = '0;
        repeat (gap) tick();
    endtask

    // Check the 1-cycle latency and the held result, then drain.
    task automatic finish_run(input string name, input logic [NL*AW-1:0] exp, input bit drain);
        @(negedge Clk);
        check({name, "_latency"}, {95'd0, Out_Valid}, {95'd0, 1'b1});
        check(name, Out_Sum, exp);
        if (drain) begin
            #1;
            Out_Ready = 1'b1;
            tick();
            Out_Ready = 1'b0;
            @(negedge Clk);
            check({name, "_drained"}, {95'd0, Out_Valid}, 96'd0);
            #1;
        end
    endtask

    task automatic run_all_ones(input string name, input int gap);
        do_start(1'b0, 1'b0);
        for (int p = 0; p < NB; p++) send_plane('1, (p == NB - 1) ? 0 : gap);
        finish_run(name, {NL{12'h7F8}}, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        check("rst_out_sum", Out_Sum, '0);
        check("rst_flags", {93'd0, Out_Valid, In_Ready, Busy}, 96'd0);
        repeat (2) tick();
        Rst = 1'b1;
        tick();

        // All planes all-ones, back-to-back.
        run_all_ones("unsigned_max", 0);

        // Single LSB in plane 0; concurrent In_Valid with Start must be ignored.
        do_start(1'b0, 1'b1);
        send_plane(64'h1, 0);
        for (int p = 1; p < NB; p++) send_plane('0, 0);
        finish_run("lane0_128", 96'd128, 1'b0);

        // Backpressure: result and flags hold while Start/In_Valid are driven.
        Start    = 1'b1;
        In_Valid = 1'b1;
        In_Data  = 64'hA5A5_5A5A_FFFF_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            check("bp_sum", Out_Sum, 96'd128);
            check("bp_flags", {94'd0, Out_Valid, In_Ready}, 96'd2);
            #1;
        end
        Start     = 1'b0;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        @(negedge Clk);
        check("bp_release", {94'd0, Out_Valid, Busy}, 96'd0);
        #1;

        // Signed: MSB plane all ones gives -1024 per lane.
        do_start(1'b1, 1'b0);
        send_plane('1, 0);
        for (int p = 1; p < NB; p++) send_plane('0, 0);
        finish_run("signed_min", {NL{12'hC00}}, 1'b1);

        // Signed mixed: lane0 = -8*128 + 4*64 = -768.
        do_start(1'b1, 1'b0);
        send_plane(64'hFF, 0);
        send_plane(64'h0F, 0);
        for (int p = 2; p < NB; p++) send_plane('0, 0);
        finish_run("signed_mix", {{(NL-1){12'h000}}, 12'hD00}, 1'b1);

        // Gapped input gives the same all-ones result.
        run_all_ones("gapped", 2);

        // Reset mid-run abandons the operation immediately.
        do_start(1'b0, 1'b0);
        for (int p = 0; p < 3; p++) send_plane('1, 0);
        Rst = 1'b0;
        #1;
        check("midrst_flags", {93'd0, Out_Valid, In_Ready, Busy}, 96'd0);
        check("midrst_sum", Out_Sum, '0);
        tick();
        Rst = 1'b1;
        tick();
        run_all_ones("after_rst", 0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soafa_psum_acc.md
SOAFA_PSUM_ACC -- requirements
Module: soafa_psum_acc

Interface
REQ-001 Parameter DATA_W, default 64: width of one Macro DOut word, one input bit plane.
REQ-002 Parameter LANE_W, default 8: DOut bits per lane; NLANES = DATA_W/LANE_W = 8.
REQ-003 Parameter NBITS, default 8: input bit planes per accumulation, sent MSB plane first.
REQ-004 Parameter ACC_W, default 12: per-lane accumulator width, two's complement.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low. Ports are Clk and Rst.
REQ-006 Clk  input  1  rising-edge clock.
REQ-007 Rst  input  1  asynchronous active-low reset.
REQ-008 Start  input  1  one-cycle request to begin an accumulation; honoured only in IDLE.
REQ-009 Signed_Mode  input  1  MSB plane carries negative weight; latched on accepted Start.
REQ-010 In_Valid  input  1  In_Data holds a valid Macro DOut plane.
REQ-011 In_Data  input  DATA_W  Macro DOut word.
REQ-012 In_Ready  output  1  block accepts a plane this cycle.
REQ-013 Out_Valid  output  1  Out_Sum holds a valid result.
REQ-014 Out_Ready  input  1  consumer accepts the result.
REQ-015 Out_Sum  output  NLANES*ACC_W  per-lane results; lane k occupies bits [k*ACC_W +: ACC_W].
REQ-016 Busy  output  1  state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 IDLE: In_Ready=0 and Out_Valid=0. Start=1 clears all accumulators and the plane counter, latches Signed_Mode, and moves the FSM to ACCUM.
REQ-019 ACCUM: In_Ready=1. A plane is accepted on In_Valid&&In_Ready.
REQ-020 For each accepted plane and each lane: pc = popcount of the lane bits (0..LANE_W). acc <= (acc<<1) + pc. Exception: on plane 0 with the latched Signed_Mode=1, acc <= 0 - pc.
REQ-021 The plane counter SHALL increment on each accepted plane. Acceptance of plane NBITS-1 moves the FSM to DONE.
REQ-022 Cycles with In_Valid=0 in ACCUM SHALL leave the accumulators and the counter unchanged. Gaps SHALL NOT alter the result.
REQ-023 DONE: Out_Valid=1 starting the cycle after the last plane is accepted. Latency from last plane to Out_Valid is 1 cycle.
REQ-024 Out_Sum SHALL stay stable while Out_Valid=1 and Out_Ready=0. On Out_Valid&&Out_Ready the FSM returns to IDLE and Out_Valid deasserts in the next cycle.
REQ-025 In_Valid in IDLE or DONE SHALL be ignored. In_Ready SHALL be 0 in those states.
REQ-026 Start in ACCUM or DONE SHALL be ignored. Start and In_Valid together in IDLE: only Start takes effect.
REQ-027 ACC_W SHALL cover both ranges without wrap: unsigned max NBITS-weighted 8*255=2040, signed range -1024..+1016.
REQ-028 Out_Sum SHALL be driven directly from the accumulator registers, with no combinational path from In_Data.

Reset
REQ-029 Rst=0 SHALL asynchronously force all of the following: IDLE; accumulators, counter and latched mode to 0; Out_Valid=0, In_Ready=0, Busy=0, Out_Sum=0.
REQ-030 Reset asserted mid-ACCUM or mid-DONE SHALL abandon the operation. The next Start after release SHALL run a fresh accumulation.

Structure
REQ-031 Package soafa_pkg SHALL hold DATA_W, LANE_W, NLANES, NBITS, ACC_W and the FSM state enum.
REQ-032 Sub-module soafa_lane_popcount (LANE_W-bit in, clog2(LANE_W+1)-bit out, combinational) SHALL be instantiated NLANES times.
REQ-033 The top level SHALL hold the FSM, plane counter, accumulators and handshake logic.

Verification
REQ-034 Unsigned: Start, then 8 planes of 64'hFFFF_FFFF_FFFF_FFFF back-to-back -> Out_Valid 1 cycle after the last plane; every lane = 12'h7F8 (2040).
REQ-035 Unsigned: plane 0 = 64'h0000_0000_0000_0001, planes 1-7 = 0 -> lane0 = 12'd128, lanes 1-7 = 0.
REQ-036 Signed_Mode=1: plane 0 all ones, planes 1-7 = 0 -> every lane = 12'hC00 (-1024).
REQ-037 Backpressure: hold Out_Ready=0 for 5 cycles in DONE while driving In_Valid=1 and Start=1 -> Out_Valid and Out_Sum stable, In_Ready=0. Release Out_Ready -> IDLE next cycle.
REQ-038 Gapped input: the REQ-034 stimulus with In_Valid low for 2 cycles between planes -> identical result, 12'h7F8 per lane.
REQ-039 Reset mid-run: assert Rst=0 after 3 accepted planes -> Out_Valid=0, Busy=0, In_Ready=0 immediately. A following REQ-034 run yields 12'h7F8.
